crc_frame_sequencer: RTL and testbench

//  Frame-level controller for the CAN CRC datapath. Tracks destuffed bits of a received frame and parses IDE/RTR/DLC.

---
 rtl/crc_frame_sequencer_pkg.sv | 9 +
 rtl/crc_frame_sequencer_if.sv | 11 +
 rtl/crc_frame_sequencer_can_crc15_step.sv | 17 +
 rtl/crc_frame_sequencer.sv | 107 ++++++++++
 tb/tb_crc_frame_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/crc_frame_sequencer_pkg.sv
// crc_frame_sequencer_pkg: frame states, CAN field lengths and CRC-15 defaults
package crc_frame_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, ARB, EXT, CTRL, DATA, CRC, DELIM} state_t;
  localparam int ID_STD = 11;
  localparam int ID_EXT = 18;
  localparam int DLC_W = 4;
  localparam int CRC_W_DEF = 15;
  localparam logic [CRC_W_DEF-1:0] CRC_POLY_DEF = 15'h4599;
endpackage

// File: rtl/crc_frame_sequencer_if.sv
// crc_frame_sequencer_if: destuffer bit stream in, CRC status out
interface crc_frame_sequencer_if;
  import crc_frame_sequencer_pkg::*;
  logic bit_stb, stuff, bitval, abort;
  logic crc_en, in_crc, done, crc_ok, crc_err, form_err;
  logic [CRC_W_DEF-1:0] crc_calc, crc_rx;
  modport master(output bit_stb, stuff, bitval, abort,
                 input crc_en, crc_calc, crc_rx, in_crc, done, crc_ok, crc_err, form_err);
  modport slave(input bit_stb, stuff, bitval, abort,
                output crc_en, crc_calc, crc_rx, in_crc, done, crc_ok, crc_err, form_err);
endinterface

// File: rtl/crc_frame_sequencer_can_crc15_step.sv
// can_crc15_step: enable-gated CRC shift register; clr restarts from zero in the same cycle
module can_crc15_step #(
  parameter int W = 15,
  parameter logic [W-1:0] POLY = 15'h4599
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] crc
);
  logic [W-1:0] base;
  assign base = clr ? '0 : crc;
  always_ff @(posedge clock)
    crc <= reset ? '0 : en ? ({base[W-2:0], 1'b0} ^ ((din ^ base[W-1]) ? POLY : '0)) : base;
endmodule

// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer: walks CAN frame fields, feeds SOF..data to CRC-15, checks CRC field and delimiter
module crc_frame_sequencer import crc_frame_sequencer_pkg::*; #(
  parameter int CRC_W = CRC_W_DEF,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEF,
  parameter int MAX_BYTES = 8
) (
  input logic clock,
  input logic reset,
  crc_frame_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [6:0] cnt, cnt_n, len;
  logic [3:0] dlc_v, bytes;
  logic [2:0] dlc;
  logic rtr, ev, feed, sof, match;
  assign ev = bus.bit_stb && !bus.stuff && !bus.abort;
  assign dlc_v = {dlc, bus.bitval};
  assign bytes = (dlc_v > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc_v;
  assign len = rtr ? 7'd0 : {bytes, 3'b000};
  assign sof = feed && state == IDLE;
  assign match = bus.crc_rx == bus.crc_calc;
  assign bus.in_crc = state == CRC || state == DELIM;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    feed = 1'b0;
    if (bus.abort) state_n = IDLE;
    else if (ev)
      case (state)
        IDLE: if (!bus.bitval) begin
          state_n = ARB;
          cnt_n = '0;
          feed = 1'b1;
        end
        ARB: begin
          feed = 1'b1;
          cnt_n = cnt == 7'(ID_STD + 1) ? '0 : cnt + 7'd1;
          if (cnt == 7'(ID_STD + 1)) state_n = bus.bitval ? EXT : CTRL;
        end
        EXT: begin
          feed = 1'b1;
          cnt_n = cnt == 7'(ID_EXT + 1) ? '0 : cnt + 7'd1;
          if (cnt == 7'(ID_EXT + 1)) state_n = CTRL;
        end
        CTRL: begin
          feed = 1'b1;
          cnt_n = cnt == 7'(DLC_W) ? len : cnt + 7'd1;
          if (cnt == 7'(DLC_W)) state_n = len == '0 ? CRC : DATA;
        end
        DATA: begin
          feed = 1'b1;
          cnt_n = cnt == 7'd1 ? '0 : cnt - 7'd1;
          if (cnt == 7'd1) state_n = CRC;
        end
        CRC: begin
          cnt_n = cnt == 7'(CRC_W - 1) ? '0 : cnt + 7'd1;
          if (cnt == 7'(CRC_W - 1)) state_n = DELIM;
        end
        DELIM: state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      bus.crc_en <= 1'b0;
      bus.done <= 1'b0;
      bus.crc_ok <= 1'b0;
      bus.crc_err <= 1'b0;
      bus.form_err <= 1'b0;
      bus.crc_rx <= '0;
      rtr <= 1'b0;
      dlc <= '0;
    end else begin
      bus.crc_en <= feed;
      bus.done <= 1'b0;
      if (sof) begin
        bus.crc_rx <= '0;
        bus.crc_err <= 1'b0;
        bus.form_err <= 1'b0;
      end
      if (ev && ((state == ARB && cnt == 7'(ID_STD)) || (state == EXT && cnt == 7'(ID_EXT)))) rtr <= bus.bitval;
      if (ev && state == CTRL) dlc <= dlc_v[2:0];
      if (ev && state == CRC) bus.crc_rx <= {bus.crc_rx[CRC_W-2:0], bus.bitval};
      if (ev && state == DELIM) begin
        bus.done <= 1'b1;
        bus.crc_ok <= match && bus.bitval;
        bus.crc_err <= !match;
        bus.form_err <= !bus.bitval;
      end
    end
  can_crc15_step #(.W(CRC_W), .POLY(CRC_POLY)) u_crc (
    .clock(clock),
    .reset(reset),
    .clr(sof),
    .en(feed),
    .din(bus.bitval),
    .crc(bus.crc_calc)
  );
endmodule

// File: tb/tb_crc_frame_sequencer.sv
// tb_crc_frame_sequencer: table of directed CAN frames plus abort/reset corner sequences
module tb_crc_frame_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  crc_frame_sequencer_if ifc();
  crc_frame_sequencer dut(.clock(clock), .reset(reset), .bus(ifc.slave));
  typedef struct {
    string name;
    bit ide;
    bit [28:0] id;
    bit rtr;
    bit [3:0] dlc;
    bit [63:0] data;
    bit [14:0] cxor;
    bit delim;
    bit st;
    bit ok;
    bit cerr;
    bit ferr;
    int en;
  } vec_t;
  vec_t v[7];
  int checks = 0, failures = 0, en_cnt = 0, done_cnt = 0, sk = 0;
  bit q[$];
  logic [14:0] mcrc, cf;
  logic ev_done, real_done;
  function automatic logic [14:0] model(input bit b, input logic [14:0] c);
    logic fb;
    fb = b ^ c[14];
    c = c << 1;
    if (fb) c = c ^ 15'h4599;
    return c;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    if (ifc.crc_en) en_cnt++;
    if (ifc.done) done_cnt++;
  endtask
  task automatic strobe(input bit b, input bit s);
    ifc.bit_stb = 1'b1;
    ifc.stuff = s;
    ifc.bitval = b;
    tick();
    ev_done = ifc.done;
    ifc.bit_stb = 1'b0;
    ifc.stuff = 1'b0;
    ifc.bitval = 1'b1;
    tick();
  endtask
  task automatic put(input bit b, input bit st);
    strobe(b, 1'b0);
    real_done = ev_done;
    sk++;
    if (st && sk % 5 == 0) strobe(~b, 1'b1);
  endtask
  task automatic build(input vec_t x);
    int len;
    q.delete();
    q.push_back(1'b0);
    for (int i = 28; i >= 18; i--) q.push_back(x.ide ? x.id[i] : x.id[i-18]);
    if (x.ide) begin
      q.push_back(1'b1);
      q.push_back(1'b1);
      for (int i = 17; i >= 0; i--) q.push_back(x.id[i]);
      q.push_back(x.rtr);
      q.push_back(1'b0);
    end else begin
      q.push_back(x.rtr);
      q.push_back(1'b0);
    end
    q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) q.push_back(x.dlc[i]);
    len = x.rtr ? 0 : 8 * ((x.dlc > 8) ? 8 : int'(x.dlc));
    for (int i = 0; i < len; i++) q.push_back(x.data[63-i]);
    mcrc = '0;
    foreach (q[i]) mcrc = model(q[i], mcrc);
  endtask
  task automatic sendq(input int n, input bit st);
    for (int i = 0; i < n; i++) put(q[i], st);
  endtask
  task automatic run(input vec_t x);
    int e0, d0;
    build(x);
    sk = 0;
    e0 = en_cnt;
    d0 = done_cnt;
    sendq(q.size(), x.st);
    cf = mcrc ^ x.cxor;
    for (int i = 14; i >= 0; i--) put(cf[i], x.st);
    chk({x.name, "_in_crc"}, ifc.in_crc, 1);
    chk({x.name, "_crc_rx"}, ifc.crc_rx, cf);
    chk({x.name, "_crc_calc"}, ifc.crc_calc, mcrc);
    chk({x.name, "_no_early_done"}, done_cnt - d0, 0);
    put(x.delim, x.st);
    chk({x.name, "_done_next"}, real_done, 1);
    chk({x.name, "_done_once"}, done_cnt - d0, 1);
    chk({x.name, "_crc_ok"}, ifc.crc_ok, x.ok);
    chk({x.name, "_crc_err"}, ifc.crc_err, x.cerr);
    chk({x.name, "_form_err"}, ifc.form_err, x.ferr);
    chk({x.name, "_en_count"}, en_cnt - e0, x.en);
    chk({x.name, "_idle"}, ifc.in_crc, 0);
  endtask
  initial begin
    int d0;
    vec_t ab;
    ifc.bit_stb = 1'b0;
    ifc.stuff = 1'b0;
    ifc.bitval = 1'b1;
    ifc.abort = 1'b0;
    v[0] = '{"std_dlc0", 1'b0, 29'h0, 1'b0, 4'h0, 64'h0, 15'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19};
    v[1] = '{"crc_flip", 1'b0, 29'h0, 1'b0, 4'h0, 64'h0, 15'h4000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 19};
    v[2] = '{"delim0", 1'b0, 29'h0, 1'b0, 4'h0, 64'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19};
    v[3] = '{"std_dlc15", 1'b0, 29'h123, 1'b0, 4'hF, 64'hDEADBEEF01234567, 15'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 83};
    v[4] = '{"rtr_dlc8", 1'b0, 29'h5A5, 1'b1, 4'h8, 64'hFFFFFFFFFFFFFFFF, 15'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19};
    v[5] = '{"ext_stuff", 1'b1, 29'h1ABCDE12, 1'b0, 4'h3, 64'hA5C33C0000000000, 15'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 63};
    v[6] = '{"std_dlc2", 1'b0, 29'h7F0, 1'b0, 4'h2, 64'hF00F000000000000, 15'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 35};
    tick();
    tick();
    chk("rst_crc_en", ifc.crc_en, 0);
    chk("rst_crc_calc", ifc.crc_calc, 0);
    chk("rst_crc_rx", ifc.crc_rx, 0);
    chk("rst_in_crc", ifc.in_crc, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_crc_ok", ifc.crc_ok, 0);
    chk("rst_crc_err", ifc.crc_err, 0);
    chk("rst_form_err", ifc.form_err, 0);
    reset = 1'b0;
    tick();
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b1);
    chk("idle_ignores", en_cnt, 0);
    foreach (v[i]) run(v[i]);
    ab = '{"abort", 1'b0, 29'h3C, 1'b0, 4'h1, 64'h5A00000000000000, 15'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 27};
    build(ab);
    sk = 0;
    d0 = done_cnt;
    sendq(22, 1'b0);
    ifc.abort = 1'b1;
    ifc.bit_stb = 1'b1;
    ifc.bitval = 1'b0;
    tick();
    chk("abort_wins_en", ifc.crc_en, 0);
    ifc.abort = 1'b0;
    ifc.bit_stb = 1'b0;
    ifc.bitval = 1'b1;
    tick();
    strobe(1'b1, 1'b0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_no_en", ifc.crc_en, 0);
    run(v[0]);
    build(v[3]);
    sk = 0;
    sendq(q.size(), 1'b0);
    for (int i = 14; i >= 10; i--) put(mcrc[i], 1'b0);
    chk("rstcrc_in_crc", ifc.in_crc, 1);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    chk("rstcrc_in_crc0", ifc.in_crc, 0);
    chk("rstcrc_calc0", ifc.crc_calc, 0);
    chk("rstcrc_rx0", ifc.crc_rx, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) strobe(1'b1, 1'b0);
    chk("rstcrc_no_done", done_cnt - d0, 0);
    run(v[6]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
